// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: mode select, 2-bit
// counter encoding and the BTB entry layout.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_STATIC_NT = 2'd0,
    BP_BIMODAL   = 2'd1,
    BP_GSHARE    = 2'd2
  } bp_mode_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Tag and target are stored zero-extended to the widest supported address.
  localparam int BP_MAX_XLEN = 64;

  typedef struct packed {
    logic                   valid;
    logic                   is_jump;
    logic [BP_MAX_XLEN-1:0] tag;
    logic [BP_MAX_XLEN-1:0] target;
  } btb_entry_t;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken && c != CTR_ST)       n = c + 2'd1;
    else if (!taken && c != CTR_SNT) n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup/update bundle between the fetch/MEM pipeline (master) and the
// branch predictor (slave). Valid-qualified, no backpressure.
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 6
);
  logic             lu_valid;
  logic             lu_hold;
  logic [XLEN-1:0]  lu_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             up_valid;
  logic [XLEN-1:0]  up_pc;
  logic             up_is_jump;
  logic             up_taken;
  logic [XLEN-1:0]  up_target;
  logic [GHR_W-1:0] up_ghr;
  logic             up_mispredict;

  modport master (
    output lu_valid, lu_hold, lu_pc,
    output up_valid, up_pc, up_is_jump, up_taken, up_target, up_ghr, up_mispredict,
    input  pred_taken, pred_target, pred_ghr
  );

  modport slave (
    input  lu_valid, lu_hold, lu_pc,
    input  up_valid, up_pc, up_is_jump, up_taken, up_target, up_ghr, up_mispredict,
    output pred_taken, pred_target, pred_ghr
  );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit counters with an async read port and a
// synchronous saturating-update / load port. Reset sets every counter to WNT.
module bp_pht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output ctr_t             o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_load,
  input  ctr_t             i_load_val,
  input  logic             i_wr_taken
);

  ctr_t r_ctr [ENTRIES];

  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_WNT;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= i_wr_load ? i_load_val : ctr_next(r_ctr[i_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB + PHT, same-cycle lookup,
// MEM-stage update, optional gshare history with mispredict restore.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int       XLEN        = 32,
  parameter int       BTB_ENTRIES = 16,
  parameter int       PHT_ENTRIES = 64,
  parameter int       GHR_W       = 6,
  parameter bp_mode_t MODE        = BP_BIMODAL
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);

  localparam int IDX_W  = $clog2(BTB_ENTRIES);
  localparam int PIDX_W = $clog2(PHT_ENTRIES);
  localparam int TAG_W  = XLEN - IDX_W - 2;
  localparam logic IS_GSHARE = (MODE == BP_GSHARE);
  localparam logic IS_STATIC = (MODE == BP_STATIC_NT);

  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] h, input logic b);
    return (h << 1) | GHR_W'(b);
  endfunction

  btb_entry_t        r_btb [BTB_ENTRIES];
  logic [GHR_W-1:0]  r_ghr;

  // Lookup side
  logic [IDX_W-1:0]  w_lu_bidx;
  logic [TAG_W-1:0]  w_lu_tag;
  logic [PIDX_W-1:0] w_lu_pidx;
  btb_entry_t        w_lu_entry;
  logic              w_lu_hit;
  ctr_t              w_lu_ctr;
  logic              w_pred_taken;

  assign w_lu_bidx  = bp.lu_pc[IDX_W+1:2];
  assign w_lu_tag   = bp.lu_pc[XLEN-1:IDX_W+2];
  assign w_lu_pidx  = bp.lu_pc[PIDX_W+1:2] ^ (IS_GSHARE ? PIDX_W'(r_ghr) : '0);
  assign w_lu_entry = r_btb[w_lu_bidx];
  assign w_lu_hit   = w_lu_entry.valid && (w_lu_entry.tag == BP_MAX_XLEN'(w_lu_tag));

  assign w_pred_taken = !reset && !IS_STATIC && bp.lu_valid && w_lu_hit &&
                        (w_lu_entry.is_jump || w_lu_ctr[1]);

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ? w_lu_entry.target[XLEN-1:0] : bp.lu_pc + XLEN'(4);
  assign bp.pred_ghr    = r_ghr;

  // Update side
  logic [IDX_W-1:0]  w_up_bidx;
  logic [TAG_W-1:0]  w_up_tag;
  logic [PIDX_W-1:0] w_up_pidx;
  btb_entry_t        w_up_entry;
  logic              w_up_hit;
  logic              w_pht_we;

  assign w_up_bidx  = bp.up_pc[IDX_W+1:2];
  assign w_up_tag   = bp.up_pc[XLEN-1:IDX_W+2];
  assign w_up_pidx  = bp.up_pc[PIDX_W+1:2] ^ (IS_GSHARE ? PIDX_W'(bp.up_ghr) : '0);
  assign w_up_entry = r_btb[w_up_bidx];
  assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == BP_MAX_XLEN'(w_up_tag));
  assign w_pht_we   = bp.up_valid && !bp.up_is_jump;

  // Fresh allocations start weakly taken instead of stepping the old counter.
  bp_pht #(
    .ENTRIES (PHT_ENTRIES),
    .IDX_W   (PIDX_W)
  ) u_pht (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_lu_pidx),
    .o_rd_ctr   (w_lu_ctr),
    .i_wr_en    (w_pht_we),
    .i_wr_idx   (w_up_pidx),
    .i_wr_load  (bp.up_taken && !w_up_hit),
    .i_load_val (CTR_WT),
    .i_wr_taken (bp.up_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb[i] <= '0;
    end else if (bp.up_valid && bp.up_taken) begin
      r_btb[w_up_bidx] <= '{valid:   1'b1,
                            is_jump: bp.up_is_jump,
                            tag:     BP_MAX_XLEN'(w_up_tag),
                            target:  BP_MAX_XLEN'(bp.up_target)};
    end
  end

  // A resolved mispredict restores history and outranks the speculative shift.
  always_ff @(posedge clk) begin
    if (reset || !IS_GSHARE) begin
      r_ghr <= '0;
    end else if (bp.up_valid && bp.up_mispredict && !bp.up_is_jump) begin
      r_ghr <= ghr_shift(bp.up_ghr, bp.up_taken);
    end else if (bp.lu_valid && !bp.lu_hold && w_lu_hit && !w_lu_entry.is_jump) begin
      r_ghr <= ghr_shift(r_ghr, w_pred_taken);
    end
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{bp.up_pc[1:0], w_lu_entry.target, w_up_entry.is_jump, w_up_entry.target};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one bimodal and one gshare instance.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  branch_predictor_if #(.XLEN(32), .GHR_W(6)) bim_if ();
  branch_predictor_if #(.XLEN(32), .GHR_W(6)) gsh_if ();

  branch_predictor #(.XLEN(32), .BTB_ENTRIES(16), .PHT_ENTRIES(64), .GHR_W(6), .MODE(BP_BIMODAL))
    u_bim (.clk(clk), .reset(reset), .bp(bim_if));
  branch_predictor #(.XLEN(32), .BTB_ENTRIES(16), .PHT_ENTRIES(64), .GHR_W(6), .MODE(BP_GSHARE))
    u_gsh (.clk(clk), .reset(reset), .bp(gsh_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bim_if.lu_valid = 0; bim_if.lu_hold = 0; bim_if.up_valid = 0; bim_if.up_is_jump = 0;
    bim_if.up_taken = 0; bim_if.up_mispredict = 0; bim_if.up_ghr = '0;
    gsh_if.lu_valid = 0; gsh_if.lu_hold = 0; gsh_if.up_valid = 0; gsh_if.up_is_jump = 0;
    gsh_if.up_taken = 0; gsh_if.up_mispredict = 0; gsh_if.up_ghr = '0;
  endtask

  task automatic bim_up(input logic [31:0] pc, input logic taken, input logic jmp, input logic [31:0] tgt);
    bim_if.up_valid = 1; bim_if.up_pc = pc; bim_if.up_taken = taken;
    bim_if.up_is_jump = jmp; bim_if.up_target = tgt;
    @(negedge clk);
    bim_if.up_valid = 0; bim_if.up_taken = 0; bim_if.up_is_jump = 0;
  endtask

  task automatic bim_lu(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
    bim_if.lu_valid = 1; bim_if.lu_pc = pc;
    #1;
    check({tag, ".taken"}, 32'(bim_if.pred_taken), 32'(exp_t));
    check({tag, ".target"}, bim_if.pred_target, exp_tgt);
  endtask

  task automatic gsh_up(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic [5:0] ghr, input logic mis);
    gsh_if.up_valid = 1; gsh_if.up_pc = pc; gsh_if.up_taken = taken; gsh_if.up_is_jump = 0;
    gsh_if.up_target = tgt; gsh_if.up_ghr = ghr; gsh_if.up_mispredict = mis;
  endtask

  initial begin
    reset = 1;
    idle();
    bim_if.lu_pc = 32'h40; bim_if.up_pc = 0; bim_if.up_target = 0;
    gsh_if.lu_pc = 32'h40; gsh_if.up_pc = 0; gsh_if.up_target = 0;
    bim_if.lu_valid = 1; gsh_if.lu_valid = 1;
    // Update offered during reset must be dropped.
    bim_if.up_valid = 1; bim_if.up_pc = 32'h40; bim_if.up_taken = 1; bim_if.up_target = 32'h999;
    repeat (2) @(negedge clk);
    #1;
    check("rst.taken", 32'(bim_if.pred_taken), 32'd0);
    check("rst.target", bim_if.pred_target, 32'h44);
    reset = 0;
    idle();

    // 1: post-reset lookup
    bim_lu("t1", 32'h40, 1'b0, 32'h44);
    check("t1.ghr_bim", 32'(bim_if.pred_ghr), 32'd0);
    check("t1.ghr_gsh", 32'(gsh_if.pred_ghr), 32'd0);

    // 2: allocate taken, then two not-taken drive counter to 00
    bim_up(32'h40, 1, 0, 32'h100);
    bim_lu("t2a", 32'h40, 1'b1, 32'h100);
    bim_up(32'h40, 0, 0, 32'h0);
    bim_up(32'h40, 0, 0, 32'h0);
    bim_lu("t2b", 32'h40, 1'b0, 32'h44);

    // 3: saturation at 11
    for (int i = 0; i < 5; i++) bim_up(32'h40, 1, 0, 32'h100);
    bim_lu("t3a", 32'h40, 1'b1, 32'h100);
    bim_up(32'h40, 0, 0, 32'h0);
    bim_lu("t3b", 32'h40, 1'b1, 32'h100);
    bim_up(32'h40, 0, 0, 32'h0);
    bim_lu("t3c", 32'h40, 1'b0, 32'h44);

    // 4: jump, eviction by alias, no allocation on not-taken miss
    bim_up(32'h80, 1, 1, 32'h200);
    bim_lu("t4a", 32'h80, 1'b1, 32'h200);
    bim_lu("t4b", 32'h40, 1'b0, 32'h44);
    bim_lu("t4c", 32'hC0, 1'b0, 32'hC4);
    bim_up(32'hC0, 1, 0, 32'h300);
    bim_lu("t4d", 32'hC0, 1'b1, 32'h300);
    bim_lu("t4e", 32'h80, 1'b0, 32'h84);
    bim_up(32'h44, 1, 0, 32'h400);
    bim_up(32'h84, 0, 0, 32'h0);
    bim_lu("t4f", 32'h44, 1'b1, 32'h400);

    // 6: same-cycle lookup+update sees old state; reset mid-stream
    bim_if.lu_valid = 1; bim_if.lu_pc = 32'hC0;
    bim_if.up_valid = 1; bim_if.up_pc = 32'hC0; bim_if.up_taken = 0; bim_if.up_target = 0;
    #1;
    check("t6a.taken", 32'(bim_if.pred_taken), 32'd1);
    check("t6a.target", bim_if.pred_target, 32'h300);
    @(negedge clk);
    idle();
    bim_lu("t6b", 32'hC0, 1'b0, 32'hC4);
    reset = 1;
    bim_up(32'hC0, 1, 0, 32'h500);
    reset = 0;
    bim_lu("t6c", 32'hC0, 1'b0, 32'hC4);
    bim_lu("t6d", 32'h44, 1'b0, 32'h48);
    bim_lu("t6e", 32'h80, 1'b0, 32'h84);
    idle();

    // 5: gshare history
    gsh_up(32'h40, 1, 32'h100, 6'b0, 0);
    @(negedge clk);
    idle();
    #1;
    check("g1.ghr0", 32'(gsh_if.pred_ghr), 32'd0);
    gsh_if.lu_valid = 1; gsh_if.lu_pc = 32'h40;
    #1;
    check("g1.taken", 32'(gsh_if.pred_taken), 32'd1);
    check("g1.target", gsh_if.pred_target, 32'h100);
    @(negedge clk);
    idle();
    #1;
    check("g1.ghr_shift", 32'(gsh_if.pred_ghr), 32'h01);

    gsh_if.lu_valid = 1; gsh_if.lu_hold = 1; gsh_if.lu_pc = 32'h40;
    #1;
    check("g2.taken", 32'(gsh_if.pred_taken), 32'd0);
    check("g2.target", gsh_if.pred_target, 32'h44);
    @(negedge clk);
    idle();
    #1;
    check("g2.ghr_hold", 32'(gsh_if.pred_ghr), 32'h01);

    gsh_if.lu_valid = 1; gsh_if.lu_pc = 32'h40;
    gsh_up(32'h40, 1, 32'h100, 6'b000101, 1);
    @(negedge clk);
    idle();
    #1;
    check("g3.ghr_restore", 32'(gsh_if.pred_ghr), 32'h0B);

    gsh_if.lu_valid = 1; gsh_if.lu_pc = 32'h40;
    #1;
    check("g4.taken", 32'(gsh_if.pred_taken), 32'd0);
    check("g4.target", gsh_if.pred_target, 32'h44);
    @(negedge clk);
    idle();
    #1;
    check("g4.ghr_shift_nt", 32'(gsh_if.pred_ghr), 32'h16);

    gsh_up(32'h40, 1, 32'h100, 6'b000010, 1);
    @(negedge clk);
    idle();
    gsh_if.lu_valid = 1; gsh_if.lu_pc = 32'h40;
    #1;
    check("g5.ghr", 32'(gsh_if.pred_ghr), 32'h05);
    check("g5.taken", 32'(gsh_if.pred_taken), 32'd1);
    check("g5.target", gsh_if.pred_target, 32'h100);
    @(negedge clk);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
